// File: rtl/test_status_monitor_if.sv
// Observation bus from the core into the status monitor: decode-stage PC and
// the data-memory write port.
interface test_status_monitor_if;
  logic [31:0] pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (output pc, mem_we, mem_addr, mem_wdata);
  modport slave  (input  pc, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/test_status_monitor.sv
// Passive riscv-tests outcome monitor: watches the tohost write, the RUN cycle
// budget and a stuck decode PC, and latches a sticky verdict.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   S_RUN     | test executing, counters advancing
//   S_PASS    | tohost written with 1
//   S_FAIL    | tohost written with odd value != 1, test number latched
//   S_TIMEOUT | RUN cycle budget exhausted
//   S_HANG    | decode PC unchanged for HANG_CYCLES samples
module test_status_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          HANG_CYCLES    = 64,
  parameter int          CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  test_status_monitor_if.slave  bus,
  output logic [2:0]            state,
  output logic                  done,
  output logic                  pass,
  output logic [30:0]           fail_testnum,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PASS    = 3'd1,
    S_FAIL    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_HANG    = 3'd4
  } mon_state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HANG_LAST    = CNT_W'(HANG_CYCLES - 2);

  mon_state_e       st;
  logic [31:0]      prev_pc;
  logic [CNT_W-1:0] stuck_cnt;
  logic             tohost_hit;
  logic             pc_same;

  assign tohost_hit = bus.mem_we && (bus.mem_addr == TOHOST_ADDR) && bus.mem_wdata[0];
  assign pc_same    = (bus.pc == prev_pc);
  assign state      = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_RUN;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_testnum <= '0;
      cycle_count  <= '0;
      stuck_cnt    <= '0;
      prev_pc      <= '0;
    end else if (st == S_RUN) begin
      // counters saturate rather than wrap
      if (cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      prev_pc <= bus.pc;
      if (!pc_same)
        stuck_cnt <= '0;
      else if (stuck_cnt != '1)
        stuck_cnt <= stuck_cnt + 1'b1;

      if (tohost_hit) begin
        done <= 1'b1;
        if (bus.mem_wdata == 32'd1) begin
          st   <= S_PASS;
          pass <= 1'b1;
        end else begin
          st           <= S_FAIL;
          fail_testnum <= bus.mem_wdata[31:1];
        end
      end else if (cycle_count == TIMEOUT_LAST) begin
        st   <= S_TIMEOUT;
        done <= 1'b1;
      end else if (pc_same && stuck_cnt == HANG_LAST) begin
        st   <= S_HANG;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: directed scenarios plus random runs, checked
// every cycle against a run-length based behavioural model.
module tb_test_status_monitor;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam int          TIMEOUT = 1000;
  localparam int          HANG    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        done, pass;
  logic [30:0] fail_testnum;
  logic [31:0] cycle_count;

  test_status_monitor_if bus();

  test_status_monitor #(
    .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TIMEOUT), .HANG_CYCLES(HANG), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state(state), .done(done), .pass(pass),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  bit cmp_en  = 1'b0;

  // Model: verdict from total RUN edges and length of the current run of
  // identical PC samples (the reset value 0 counts as the first sample).
  int          m_state;
  int          m_cycles;
  int          m_run;
  logic [31:0] m_last_pc;
  logic [30:0] m_ftn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_cycles = 0; m_run = 1; m_last_pc = 32'h0; m_ftn = '0;
    end else if (m_state == 0) begin
      m_cycles = m_cycles + 1;
      m_run = (bus.pc == m_last_pc) ? m_run + 1 : 1;
      m_last_pc = bus.pc;
      if (bus.mem_we && bus.mem_addr == TOHOST && bus.mem_wdata[0]) begin
        if (bus.mem_wdata == 32'd1) m_state = 1;
        else begin
          m_state = 2;
          m_ftn = bus.mem_wdata[31:1];
        end
      end else if (m_cycles == TIMEOUT) m_state = 3;
      else if (m_run >= HANG) m_state = 4;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      n_tests++;
      if (state !== 3'(m_state) || done !== (m_state != 0) || pass !== (m_state == 1) ||
          fail_testnum !== m_ftn || cycle_count !== 32'(m_cycles)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got st=%0d done=%0b pass=%0b ftn=%0d cc=%0d expected st=%0d ftn=%0d cc=%0d",
                 $time, state, done, pass, fail_testnum, cycle_count, m_state, m_ftn, m_cycles);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    bus.pc = p; bus.mem_we = we; bus.mem_addr = a; bus.mem_wdata = d;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pc = 32'h0; bus.mem_we = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    edges = 0;
  endtask

  task automatic run_to(input int last_edge);
    while (edges < last_edge) drive(32'h100 + 32'(edges + 1) * 4, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] cur_pc;
    rst = 1'b1;
    do_reset();
    check("reset_state", {state, done, pass}, {3'd0, 1'b0, 1'b0});
    check("reset_cc", cycle_count, 0);
    check("reset_ftn", fail_testnum, 0);
    cmp_en = 1'b1;

    // T1 pass at edge 37, then holds
    run_to(36);
    drive(32'h100 + 37 * 4, 1'b1, TOHOST, 32'd1);
    check("t1_state", state, 1);
    check("t1_pass", pass, 1);
    check("t1_cc", cycle_count, 37);
    repeat (20) drive($urandom, 1'b1, TOHOST, 32'd7);
    check("t1_hold", {state, cycle_count}, {3'd1, 32'd37});

    // T2 fail with test number 3, later pass write ignored
    do_reset();
    run_to(36);
    drive(32'h100 + 37 * 4, 1'b1, TOHOST, 32'h7);
    check("t2_state", state, 2);
    check("t2_ftn", fail_testnum, 3);
    check("t2_pass", pass, 0);
    drive(32'h400, 1'b1, TOHOST, 32'd1);
    check("t2_sticky", state, 2);

    // T3 ignored writes and tohost beating timeout
    do_reset();
    drive(32'h104, 1'b1, TOHOST, 32'h2);
    check("t3_even", state, 0);
    drive(32'h108, 1'b1, TOHOST + 4, 32'd1);
    check("t3_addr", state, 0);
    run_to(TIMEOUT - 1);
    drive(32'h9000, 1'b1, TOHOST, 32'd1);
    check("t3_prio", {state, cycle_count}, {3'd1, 32'(TIMEOUT)});

    // T4 timeout
    do_reset();
    run_to(TIMEOUT - 1);
    check("t4_pre", state, 0);
    run_to(TIMEOUT);
    check("t4_state", {state, done}, {3'd3, 1'b1});
    check("t4_cc", cycle_count, TIMEOUT);

    // T5 hang at edge 73, then delayed by one PC change
    do_reset();
    for (int i = 1; i <= 9; i++) drive(32'h200 + 32'(i) * 4, 1'b0, 32'h0, 32'h0);
    while (edges < 72) drive(32'h100, 1'b0, 32'h0, 32'h0);
    check("t5_pre", state, 0);
    drive(32'h100, 1'b0, 32'h0, 32'h0);
    check("t5_hang", state, 4);
    do_reset();
    for (int i = 1; i <= 9; i++) drive(32'h200 + 32'(i) * 4, 1'b0, 32'h0, 32'h0);
    while (edges < 103) drive((edges == 39) ? 32'h104 : 32'h100, 1'b0, 32'h0, 32'h0);
    check("t5_delay_pre", state, 0);
    drive(32'h100, 1'b0, 32'h0, 32'h0);
    check("t5_delay_hang", state, 4);

    // T6 async reset from FAIL
    do_reset();
    run_to(5);
    drive(32'h500, 1'b1, TOHOST, 32'h21);
    check("t6_fail", {state, fail_testnum}, {3'd2, 31'd16});
    rst = 1'b1;
    #2;
    check("t6_async", {state, done, pass, fail_testnum, cycle_count},
          {3'd0, 1'b0, 1'b0, 31'd0, 32'd0});
    do_reset();
    run_to(8);
    drive(32'h600, 1'b1, TOHOST, 32'd1);
    check("t6_rerun", {state, cycle_count}, {3'd1, 32'd9});

    // random runs
    for (int r = 0; r < 8; r++) begin
      int hold_pct;
      hold_pct = (r == 3) ? 99 : 60;
      do_reset();
      cur_pc = 32'h100;
      for (int c = 0; c < 400; c++) begin
        logic        we;
        logic [31:0] a, d;
        if ($urandom_range(0, 99) >= hold_pct) cur_pc = cur_pc + 4;
        we = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0, 1: a = TOHOST;
          2:    a = TOHOST + 4;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       d = 32'd1;
          1:       d = {$urandom} & 32'hFFFF_FFFE;
          default: d = {$urandom} | 32'h1;
        endcase
        drive(cur_pc, we, a, d);
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
